// File: rtl/mux_scan_sequencer_pkg.sv
// mux_scan_sequencer_pkg
//   Shared definitions for the mux scan sequencer: channel count, select
//   width and the sequencer state encoding.
package mux_scan_sequencer_pkg;

    localparam int unsigned NCH = 4;  // channels behind the 4:1 mux
    localparam int unsigned SW  = 2;  // select width

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHold = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/mux_next_sel.sv
// mux_next_sel
//   Combinational next-enabled-channel finder.
//   Ports:
//     mask  [NCH-1:0] in  : channel enable mask
//     cur   [SW-1:0]  in  : current channel index
//     first           in  : 1 = return lowest enabled channel, ignore cur
//     nxt   [SW-1:0]  out : lowest enabled index (above cur unless first)
//     valid           out : an eligible channel exists
module mux_next_sel
    import mux_scan_sequencer_pkg::*;
(
    input  logic [NCH-1:0] mask,
    input  logic [SW-1:0]  cur,
    input  logic           first,
    output logic [SW-1:0]  nxt,
    output logic           valid
);

    always_comb begin
        nxt   = '0;
        valid = 1'b0;
        // Scan downwards so the last hit written is the lowest eligible index.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && (first || (SW'(i) > cur))) begin
                nxt   = SW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//   Steps the select of a 4:1 mux through every enabled channel in ascending
//   order, holds each select for DWELL cycles, samples the mux output at the
//   end of each dwell and publishes the rebuilt 4-bit word with a done pulse.
//   Ports:
//     clk            in  : clock, rising edge
//     rst            in  : synchronous active-high reset
//     start          in  : scan request, honoured only when idle
//     en    [3:0]    in  : channel enable mask, latched on accepted start
//     z              in  : mux output
//     s     [1:0]    out : mux select
//     busy           out : scan in progress
//     done           out : one-cycle pulse, q valid from this cycle
//     q     [3:0]    out : assembled word, disabled channels read 0
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int unsigned DWELL = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [NCH-1:0] en,
    input  logic           z,
    output logic [SW-1:0]  s,
    output logic           busy,
    output logic           done,
    output logic [NCH-1:0] q
);

    localparam logic [7:0] CntInit = 8'(DWELL - 1);

    state_e         state_q, state_d;
    logic [SW-1:0]  s_q, s_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [NCH-1:0] q_q, q_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [NCH-1:0] shadow_q, shadow_d;
    logic [NCH-1:0] mask_q, mask_d;

    logic [NCH-1:0] shadow_smp;
    logic [NCH-1:0] sel_mask;
    logic           sel_first;
    logic [SW-1:0]  nxt_idx;
    logic           nxt_valid;

    // One finder serves both paths: in IDLE it looks at the live mask for the
    // first channel, in HOLD at the latched mask for the next one.
    assign sel_first = (state_q == StIdle);
    assign sel_mask  = sel_first ? en : mask_q;

    mux_next_sel u_next_sel (
        .mask  (sel_mask),
        .cur   (s_q),
        .first (sel_first),
        .nxt   (nxt_idx),
        .valid (nxt_valid)
    );

    always_comb begin
        shadow_smp      = shadow_q;
        shadow_smp[s_q] = z;
    end

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        q_d      = q_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        mask_d   = mask_q;

        case (state_q)
            StIdle: begin
                s_d    = '0;
                busy_d = 1'b0;
                if (start) begin
                    mask_d   = en;
                    shadow_d = '0;
                    if (!nxt_valid) begin
                        // Empty mask: publish an all-zero word right away.
                        state_d = StDone;
                        done_d  = 1'b1;
                        q_d     = '0;
                    end else begin
                        s_d     = nxt_idx;
                        cnt_d   = CntInit;
                        busy_d  = 1'b1;
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    shadow_d = shadow_smp;
                    if (nxt_valid) begin
                        s_d   = nxt_idx;
                        cnt_d = CntInit;
                    end else begin
                        // done and q are registered, so load them on entry to
                        // DONE; q includes the bit sampled this cycle.
                        state_d = StDone;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        s_d     = '0;
                        q_d     = shadow_smp;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                s_d     = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                s_d     = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            s_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            q_q      <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
        end
    end

    assign s    = s_q;
    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;

endmodule
